// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder
// Description : Bit-serial adder, LSB first, one full-adder step per clock.
//               Computes {co,s} = a + b + ci in WIDTH RUN cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_s;
    logic             r_co;

    logic             w_sbit;
    logic             w_cbit;
    logic             w_last;
    logic             w_accept;

    assign w_sbit   = r_a[0] ^ r_b[0] ^ r_c;
    assign w_cbit   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));
    assign w_accept = start && (r_state != ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // s/co are loaded only from the finished sum so partial results never show.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sum <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_s   <= '0;
            r_co  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_sum <= '0;
            r_c   <= ci;
            r_cnt <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum <= {w_sbit, r_sum[WIDTH-1:1]};
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_c   <= w_cbit;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) begin
                r_s  <= {w_sbit, r_sum[WIDTH-1:1]};
                r_co <= w_cbit;
            end
        end
    end

    assign busy = (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);
    assign s    = r_s;
    assign co   = r_co;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder
// Description : Self-checking bench for serial_adder with a timing-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             co;

    int checks   = 0;
    int failures = 0;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start at edge k0 yields its result at edge k0+WIDTH;
    // start is honoured whenever no operation is outstanding.
    int               k      = 0;
    int               e0     = 0;
    bit               have_op = 1'b0;
    bit               armed  = 1'b0;
    logic [WIDTH:0]   opsum  = '0;
    logic [WIDTH-1:0] exp_s  = '0;
    logic             exp_co = 1'b0;
    logic             exp_done = 1'b0;
    logic             exp_busy = 1'b0;

    always @(posedge clk) begin
        k = k + 1;
        if (rst) begin
            armed    = 1'b1;
            have_op  = 1'b0;
            exp_s    = '0;
            exp_co   = 1'b0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (have_op && k == e0 + WIDTH) begin
                {exp_co, exp_s} = opsum;
                exp_done = 1'b1;
                have_op  = 1'b0;
            end else if (start && !have_op) begin
                have_op = 1'b1;
                e0      = k;
                opsum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
            end
            exp_busy = have_op && (k < e0 + WIDTH);
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("done", 32'(done), 32'(exp_done));
            chk("s",    32'(s),    32'(exp_s));
            chk("co",   32'(co),   32'(exp_co));
        end
    end

    // Waits for done after an accept edge; checks latency, busy span and literal result.
    task automatic wait_done(input logic [WIDTH-1:0] es, input logic eco, input string name);
        int n;
        int busyn;
        n     = 0;
        busyn = 0;
        for (int i = 1; i <= WIDTH + 4; i++) begin
            @(negedge clk);
            if (busy) busyn++;
            if (done) begin
                n = i;
                break;
            end
        end
        chk({name, "_latency"}, 32'(n), 32'(WIDTH + 1));
        chk({name, "_busycycles"}, 32'(busyn), 32'(WIDTH));
        chk({name, "_s"}, 32'(s), 32'(es));
        chk({name, "_co"}, 32'(co), 32'(eco));
    endtask

    task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v, input logic tci);
        @(posedge clk); #1;
        start = 1'b1; a = ta; b = tb_v; ci = tci;
        @(posedge clk); #1;
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); ci = 1'($urandom);
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   rsum;
        int               nd;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_s",    32'(s),    32'd0);
        chk("reset_co",   32'(co),   32'd0);

        launch(8'h00, 8'h00, 1'b0); wait_done(8'h00, 1'b0, "zero");
        launch(8'hFF, 8'h01, 1'b0); wait_done(8'h00, 1'b1, "wrap");
        launch(8'hA5, 8'h5A, 1'b1); wait_done(8'h00, 1'b1, "a5_5a_ci");
        launch(8'h7F, 8'h01, 1'b0); wait_done(8'h80, 1'b0, "7f_01");

        // Abort: reset sampled at the end of the 4th RUN cycle.
        launch(8'h0F, 8'h0F, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s",    32'(s),    32'd0);
        chk("abort_co",   32'(co),   32'd0);
        nd = 0;
        for (int i = 0; i < WIDTH + 4; i++) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);

        // start held high through RUN while operands change.
        @(posedge clk); #1;
        start = 1'b1; a = 8'h3C; b = 8'h0F; ci = 1'b0;
        @(posedge clk); #1;
        a = 8'h11; b = 8'h22;
        wait_done(8'h4B, 1'b0, "held_first");
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(8'h33, 1'b0, "held_second");

        // Back-to-back: new start presented in the DONE cycle.
        launch(8'h55, 8'h22, 1'b0); wait_done(8'h77, 1'b0, "pre_b2b");
        start = 1'b1; a = 8'h12; b = 8'h34; ci = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(8'h46, 1'b0, "b2b");

        // Random operations with random idle gaps.
        for (int t = 0; t < 24; t++) begin
            ra   = WIDTH'($urandom);
            rb   = WIDTH'($urandom);
            rc   = 1'($urandom);
            rsum = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            repeat ($urandom_range(0, 2)) @(posedge clk);
            launch(ra, rb, rc);
            wait_done(rsum[WIDTH-1:0], rsum[WIDTH], "rand");
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
